// File: rtl/hidden_layer_writer.sv
// hidden_layer_writer
// Time-multiplexed hidden layer. A single signed MAC evaluates N_NEUR neurons one
// after another (N_IN products + bias each), applies ReLU with 8-bit saturation and
// packs each result into its byte slot of outreg.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : begin a layer computation (sampled only when idle)
//   x_in            : N_IN signed bytes, element k at [8k+7:8k], stable while busy
//   w, b            : signed weight / bias returned by the external combinational ROM
//   neuron_idx      : ROM address high part (current neuron)
//   tap_idx         : ROM address low part (current input tap)
//   outreg          : packed activations, neuron j at [8j+7:8j]
//   busy            : computation in progress
//   done            : one-cycle pulse after the last slot is written
//   outreg_valid    : level, outreg complete and stable
module hidden_layer_writer #(
  parameter int unsigned N_IN   = 8,
  parameter int unsigned N_NEUR = 10,
  parameter int unsigned ACC_W  = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_IN*8-1:0]       x_in,
  input  logic signed [7:0]       w,
  input  logic signed [7:0]       b,
  output logic [3:0]              neuron_idx,
  output logic [2:0]              tap_idx,
  output logic [N_NEUR*8-1:0]     outreg,
  output logic                    busy,
  output logic                    done,
  output logic                    outreg_valid
);

  typedef enum logic [1:0] {StIdle, StMac, StBias, StWrite} state_e;

  state_e                  r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [3:0]              r_neuron;
  logic [2:0]              r_tap;
  logic [N_NEUR*8-1:0]     r_outreg;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_valid;

  logic signed [7:0]       w_x;
  logic signed [15:0]      w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic [7:0]              w_relu;

  // Select input element for the current tap.
  always_comb begin
    w_x = '0;
    for (int k = 0; k < int'(N_IN); k++) begin
      if (r_tap == k[2:0]) begin
        w_x = x_in[8*k +: 8];
      end
    end
  end

  always_comb begin
    w_prod     = w_x * w;
    w_prod_ext = {{(ACC_W-16){w_prod[15]}}, w_prod};
    w_bias_ext = {{(ACC_W-8){b[7]}}, b};
  end

  // ReLU with saturation: a non-negative acc exceeds 127 when any bit above bit 6 is set.
  always_comb begin
    if (r_acc[ACC_W-1]) begin
      w_relu = 8'd0;
    end else if (|r_acc[ACC_W-2:7]) begin
      w_relu = 8'd127;
    end else begin
      w_relu = r_acc[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_acc    <= '0;
      r_neuron <= '0;
      r_tap    <= '0;
      r_outreg <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state  <= StMac;
            r_acc    <= '0;
            r_neuron <= '0;
            r_tap    <= '0;
            r_outreg <= '0;
            r_busy   <= 1'b1;
            r_valid  <= 1'b0;
          end
        end
        StMac: begin
          r_acc <= r_acc + w_prod_ext;
          if (r_tap == 3'(N_IN-1)) begin
            r_tap   <= '0;
            r_state <= StBias;
          end else begin
            r_tap <= r_tap + 3'd1;
          end
        end
        StBias: begin
          r_acc   <= r_acc + w_bias_ext;
          r_state <= StWrite;
        end
        StWrite: begin
          for (int j = 0; j < int'(N_NEUR); j++) begin
            if (r_neuron == j[3:0]) begin
              r_outreg[8*j +: 8] <= w_relu;
            end
          end
          r_acc <= '0;
          if (r_neuron < 4'(N_NEUR-1)) begin
            r_neuron <= r_neuron + 4'd1;
            r_state  <= StMac;
          end else begin
            r_neuron <= '0;
            r_state  <= StIdle;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_valid  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign neuron_idx   = r_neuron;
  assign tap_idx      = r_tap;
  assign outreg       = r_outreg;
  assign busy         = r_busy;
  assign done         = r_done;
  assign outreg_valid = r_valid;

endmodule

// File: tb/tb_hidden_layer_writer.sv
module tb_hidden_layer_writer;
  localparam int N_IN   = 8;
  localparam int N_NEUR = 10;
  localparam int ACC_W  = 24;
  localparam int RUN    = N_NEUR * (N_IN + 2);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [N_IN*8-1:0] x_in;
  logic signed [7:0] w;
  logic signed [7:0] b;
  logic [3:0]        neuron_idx;
  logic [2:0]        tap_idx;
  logic [79:0]       outreg;
  logic              busy;
  logic              done;
  logic              outreg_valid;

  int checks   = 0;
  int failures = 0;

  logic signed [7:0] rom_w [N_NEUR][N_IN];
  logic signed [7:0] rom_b [N_NEUR];
  logic [79:0]       sb_q [$];
  logic [79:0]       mon_exp;

  hidden_layer_writer #(
    .N_IN   (N_IN),
    .N_NEUR (N_NEUR),
    .ACC_W  (ACC_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .x_in         (x_in),
    .w            (w),
    .b            (b),
    .neuron_idx   (neuron_idx),
    .tap_idx      (tap_idx),
    .outreg       (outreg),
    .busy         (busy),
    .done         (done),
    .outreg_valid (outreg_valid)
  );

  always #5 clk = ~clk;

  // Combinational ROM model.
  always_comb begin
    w = '0;
    b = '0;
    if (int'(neuron_idx) < N_NEUR && int'(tap_idx) < N_IN) begin
      w = rom_w[neuron_idx][tap_idx];
      b = rom_b[neuron_idx];
    end
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: dot product + bias in plain integer arithmetic, then clamp to 0..127.
  function automatic logic [79:0] model();
    logic [79:0] res;
    res = '0;
    for (int j = 0; j < N_NEUR; j++) begin
      int acc;
      acc = int'(rom_b[j]);
      for (int t = 0; t < N_IN; t++) begin
        acc += int'($signed(x_in[8*t +: 8])) * int'(rom_w[j][t]);
      end
      if (acc < 0) acc = 0;
      if (acc > 127) acc = 127;
      res[8*j +: 8] = 8'(acc);
    end
    return res;
  endfunction

  // Monitor: every done pulse consumes one expected vector.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("outreg_at_done", outreg, mon_exp);
        chk("valid_at_done", 80'(outreg_valid), 80'd1);
      end
    end
  end

  task automatic chk_zero(input string name);
    chk({name, "_outreg"}, outreg, 80'd0);
    chk({name, "_busy"}, 80'(busy), 80'd0);
    chk({name, "_done"}, 80'(done), 80'd0);
    chk({name, "_valid"}, 80'(outreg_valid), 80'd0);
    chk({name, "_nidx"}, 80'(neuron_idx), 80'd0);
    chk({name, "_tidx"}, 80'(tap_idx), 80'd0);
  endtask

  task automatic set_x_all(input logic [7:0] v);
    for (int t = 0; t < N_IN; t++) x_in[8*t +: 8] = v;
  endtask

  task automatic set_rom_const(input logic signed [7:0] wv, input logic signed [7:0] bv);
    for (int j = 0; j < N_NEUR; j++) begin
      rom_b[j] = bv;
      for (int t = 0; t < N_IN; t++) rom_w[j][t] = wv;
    end
  endtask

  task automatic set_random(input int xr, input int wr, input int br);
    for (int t = 0; t < N_IN; t++) x_in[8*t +: 8] = 8'(int'($urandom_range(0, 2*xr)) - xr);
    for (int j = 0; j < N_NEUR; j++) begin
      rom_b[j] = 8'(int'($urandom_range(0, 2*br)) - br);
      for (int t = 0; t < N_IN; t++) rom_w[j][t] = 8'(int'($urandom_range(0, 2*wr)) - wr);
    end
  endtask

  // Accept edge (edge 0); optionally records the expected result.
  task automatic start_run(input bit push);
    if (push) sb_q.push_back(model());
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("accept_busy", 80'(busy), 80'd1);
    chk("accept_valid", 80'(outreg_valid), 80'd0);
    chk("accept_clear", outreg, 80'd0);
  endtask

  // Entered at #1 after edge 0; returns at #1 after edge RUN (or after an abort).
  task automatic run_body(input int glitch_at, input int rst_at, output bit aborted);
    aborted = 1'b0;
    for (int e = 0; e < RUN; e++) begin
      int nxt, j, t;
      nxt = e + 1;
      j   = (nxt - 1) / (N_IN + 2);
      t   = (nxt - 1) % (N_IN + 2);
      if (t >= N_IN) t = 0;
      chk("rom_neuron_idx", 80'(neuron_idx), 80'(j));
      chk("rom_tap_idx", 80'(tap_idx), 80'(t));
      chk("run_busy", 80'(busy), 80'd1);
      chk("run_done", 80'(done), 80'd0);
      if (e == glitch_at) start = 1'b1;
      if (e == glitch_at + 1) start = 1'b0;
      if (e == rst_at) begin
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        @(posedge clk);
        @(posedge clk);
        #1 chk_zero("rst_held");
        rst = 1'b0;
        @(posedge clk);
        #1 chk_zero("rst_released");
        aborted = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("end_done", 80'(done), 80'd1);
    chk("end_busy", 80'(busy), 80'd0);
    chk("end_valid", 80'(outreg_valid), 80'd1);
    chk("end_nidx", 80'(neuron_idx), 80'd0);
  endtask

  task automatic finish_run();
    @(posedge clk);
    #1;
    chk("done_fall", 80'(done), 80'd0);
    chk("valid_hold", 80'(outreg_valid), 80'd1);
    chk("idle_busy", 80'(busy), 80'd0);
  endtask

  task automatic do_run(input int glitch_at, input int rst_at);
    bit ab;
    start_run(rst_at < 0);
    run_body(glitch_at, rst_at, ab);
    if (!ab) finish_run();
  endtask

  initial begin
    bit ab;
    rst   = 1'b1;
    start = 1'b0;
    x_in  = '0;
    set_rom_const(8'sd0, 8'sd0);
    repeat (3) @(posedge clk);
    #1 chk_zero("reset_hold");
    rst = 1'b0;
    @(posedge clk);
    #1 chk_zero("after_reset");

    // Uniform: 8 * 1 * 1 = 8
    set_x_all(8'd1);
    set_rom_const(8'sd1, 8'sd0);
    do_run(-1, -1);
    chk("uniform_value", outreg, {10{8'h08}});

    // Negative clamp: -8 + 5 = -3
    set_rom_const(-8'sd1, 8'sd5);
    do_run(-1, -1);
    chk("neg_clamp_value", outreg, 80'd0);

    // Saturation, positive operands
    set_x_all(8'd127);
    set_rom_const(8'sd127, 8'sd127);
    do_run(-1, -1);
    chk("sat_pos_value", outreg, {10{8'h7F}});

    // Saturation, both operands -128
    set_x_all(8'h80);
    set_rom_const(-8'sd128, 8'sd0);
    do_run(-1, -1);
    chk("sat_neg_value", outreg, {10{8'h7F}});

    // Packing order: slot j = 7j + 8
    set_x_all(8'd1);
    for (int j = 0; j < N_NEUR; j++) begin
      rom_b[j] = 8'(-j);
      for (int t = 0; t < N_IN; t++) rom_w[j][t] = 8'(j + 1);
    end
    do_run(-1, -1);
    for (int j = 0; j < N_NEUR; j++) chk("pack_slot", 80'(outreg[8*j +: 8]), 80'(7*j + 8));

    // Boundary around 127: 128 + bias, bias = -1 - 14j
    set_rom_const(8'sd16, 8'sd0);
    for (int j = 0; j < N_NEUR; j++) rom_b[j] = 8'(-1 - 14*j);
    do_run(-1, -1);

    // Start glitch mid-run is ignored
    set_random(8, 6, 40);
    do_run(29, -1);

    // Reset at cycle 50, then a clean run
    set_random(8, 6, 40);
    do_run(-1, 50);
    do_run(-1, -1);

    // Randomised runs
    for (int r = 0; r < 4; r++) begin
      if (r == 3) set_random(128, 127, 127);
      else set_random(8, 6, 40);
      do_run(-1, -1);
    end

    // Start held through done: immediate restart
    set_random(8, 6, 40);
    start_run(1'b1);
    run_body(-1, -1, ab);
    start = 1'b1;
    set_random(8, 6, 40);
    sb_q.push_back(model());
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("restart_busy", 80'(busy), 80'd1);
    chk("restart_valid", 80'(outreg_valid), 80'd0);
    chk("restart_clear", outreg, 80'd0);
    chk("restart_done", 80'(done), 80'd0);
    run_body(-1, -1, ab);
    finish_run();

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 80'(sb_q.size()), 80'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hidden_layer_writer.md
# hidden_layer_writer

- Time-multiplexed hidden layer that produces the packed 80-bit activation register consumed by the output neuron.
- One shared signed MAC computes 10 hidden neurons in sequence. Each neuron is 8 input-by-weight products plus bias, followed by ReLU with saturation to 8 bits.
- Each result is written into its slot of `outreg`. When the vector is complete, the block pulses `done` and holds `outreg_valid`, which the output neuron uses as its start enable.
- Weights and biases come from an external combinational ROM addressed by this block.

## Interface
Parameters:
- `N_IN`, 8: inputs per hidden neuron.
- `N_NEUR`, 10: hidden neurons; `outreg` width is `N_NEUR*8`.
- `ACC_W`, 24: accumulator width.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: request a layer computation; sampled only in IDLE.
- `x_in`, in, `N_IN*8`: signed 8-bit input vector. Element k is `x_in[8k+7:8k]`. Held stable while `busy`.
- `w`, in, 8 (signed): weight for (`neuron_idx`, `tap_idx`). Valid in the same cycle as the address.
- `b`, in, 8 (signed): bias for `neuron_idx`. Valid in the same cycle as the address.
- `neuron_idx`, out, 4: current neuron (ROM address high part).
- `tap_idx`, out, 3: current input tap (ROM address low part).
- `outreg`, out, `N_NEUR*8`: packed activations. Neuron j is at `[8j+7:8j]`.
- `busy`, out, 1: computation in progress.
- `done`, out, 1: one-cycle pulse after the last slot is written.
- `outreg_valid`, out, 1: level; `outreg` complete and stable.

## Operation
- States: IDLE, MAC, BIAS, WRITE.
- **IDLE**
  - `start`=1 at an edge: go to MAC.
  - Clear `outreg`, `acc`, `neuron_idx` and `tap_idx`.
  - Drop `outreg_valid`, set `busy`.
- **MAC**
  - Each edge: `acc <= acc + sext(x_in[tap_idx]) * w`. The 8x8 signed product is 16 bits, sign-extended to `ACC_W`.
  - `tap_idx` increments; after tap `N_IN-1` it wraps to 0 and the state goes to BIAS.
- **BIAS**: one edge, `acc <= acc + sext(b)`; go to WRITE.
- **WRITE**
  - One edge; write `relu_sat(acc)` into slot `neuron_idx` and clear `acc`.
  - If `neuron_idx < N_NEUR-1`: increment `neuron_idx`, go to MAC.
  - Otherwise: go to IDLE, `busy`<=0, `done`<=1, `outreg_valid`<=1, and `neuron_idx` returns to 0.
- **relu_sat(acc)**
  - `acc < 0` -> 0.
  - `acc > 127` -> 127.
  - Otherwise `acc[7:0]`.
  - Output is always in 0..127, so the output neuron may treat slots as signed.
- `start` while `busy`: ignored, no effect on the current run.
- `start` high in the cycle `done` is high: accepted (state is IDLE). This begins a new run and drops `outreg_valid` at that edge.
- Reset (any time, including mid-run):
  - state IDLE;
  - `acc`, `outreg`, `neuron_idx`, `tap_idx`, `busy`, `done` and `outreg_valid` all 0.
  - No partial result survives.

## Timing
- Reset values: every output is 0.
- Edge 0 is the edge that accepts `start`.
- Per neuron: `N_IN+2` cycles, i.e. `N_IN` MAC cycles, 1 BIAS, 1 WRITE.
- Neuron j MAC taps occur on edges `(N_IN+2)j+1 .. (N_IN+2)j+N_IN`.
- Neuron j BIAS is on edge `(N_IN+2)j+N_IN+1`; its slot is written on edge `(N_IN+2)(j+1)`.
- Defaults: slot j is written at edge 10(j+1). `done`, `outreg_valid` and `busy`=0 all take effect at edge 100 (`N_NEUR*(N_IN+2)`). `done` falls at edge 101.
- `neuron_idx`/`tap_idx` are registered. `w`/`b` are sampled at the same edge that uses them, so the ROM has one full cycle of combinational time.
- `outreg` slots change only at WRITE edges and on a `start`-accept clear. `outreg_valid` stays high until the next accepted `start` or reset.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle -> all outputs 0 immediately; hold and release -> state IDLE, still 0.
- **Uniform:**
  - Stimulus: `x_in` all 1, ROM `w`=1, `b`=0, pulse `start`.
  - Response: `outreg` = every byte 0x08; `done` high exactly one cycle after edge 100, `busy` high edges 0..100.
- **Negative clamp:** `x_in` all 1, `w`=-1, `b`=5 -> acc=-3 -> every byte 0x00, `outreg_valid`=1.
- **Saturation:** `x_in` all 127, `w`=127, `b`=127 -> acc=129159 -> every byte 0x7F; also `x`=-128, `w`=-128 -> 0x7F.
- **Packing order:**
  - Stimulus: `x_in` all 1, `w` = `neuron_idx`+1, `b` = -`neuron_idx`.
  - Response: slot j = 7j+8, i.e. bytes 0x08, 0x0F, ... 0x47, at `[8j+7:8j]`.
  - Also check the `neuron_idx`/`tap_idx` sequence against the ROM model.
- **Control corners:**
  - `start` pulsed at cycle 30 of a run -> ignored, result unchanged.
  - `rst` at cycle 50 -> all outputs 0, IDLE; a new `start` then completes with correct values at edge 100 of the new run.
  - `start` held high through `done` -> immediate restart and `outreg_valid` cleared.
